// File: rtl/motion_pkg.sv
// Shared definitions for the motion threshold filter: display modes, the default
// overlay colour and the pixel pipeline latency.
package motion_pkg;

  typedef enum logic [1:0] {
    MODE_PASS    = 2'd0,
    MODE_OVERLAY = 2'd1,
    MODE_MASK    = 2'd2,
    MODE_DIFF    = 2'd3
  } mode_e;

  localparam int unsigned DEF_CH_W = 8;
  localparam logic [3*DEF_CH_W-1:0] DEF_OVERLAY = {{DEF_CH_W{1'b1}}, {(2*DEF_CH_W){1'b0}}};

  // Diff register + flag register + (RUN_LEN-1) cycles of run-filter look-ahead.
  function automatic int unsigned pipe_latency(input int unsigned run_len);
    return run_len + 1;
  endfunction

endpackage

// File: rtl/motion_run_filter.sv
// 1-D horizontal opening: a pixel survives iff it lies inside a run of at least
// RUN_LEN consecutive set flags. Marked output lags the registered flag by RUN_LEN-1.
module motion_run_filter #(
  parameter int unsigned RUN_LEN = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic flag_i,
  output logic marked_o
);

  localparam int unsigned SrW = 2 * RUN_LEN - 1;

  logic [SrW-1:0] sr_q, sr_d;

  always_comb begin
    sr_d = (sr_q << 1) | SrW'(flag_i);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  // Centre pixel sits at sr_q[RUN_LEN-1]; every window j..j+RUN_LEN-1 with j < RUN_LEN covers it.
  always_comb begin
    marked_o = 1'b0;
    for (int j = 0; j < RUN_LEN; j++) begin
      marked_o = marked_o | (&sr_q[j +: RUN_LEN]);
    end
  end

endmodule

// File: rtl/motion_threshold_filter.sv
// Frame-differencing motion detector: |curr-prev| threshold, run filter, re-colouring
// and per-frame motion statistics, with configuration shadowed at vsync.
module motion_threshold_filter
  import motion_pkg::*;
#(
  parameter int unsigned        CH_W          = 8,
  parameter int unsigned        PIX_W         = 8,
  parameter int unsigned        RUN_LEN       = 3,
  parameter int unsigned        CNT_W         = 22,
  parameter logic [PIX_W-1:0]   DEF_THRESHOLD = PIX_W'(128),
  parameter logic [3*CH_W-1:0]  OVERLAY       = {{CH_W{1'b1}}, {(2*CH_W){1'b0}}}
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [3*CH_W-1:0]    i_vid_data,
  input  logic                 i_vid_hsync,
  input  logic                 i_vid_vsync,
  input  logic                 i_vid_VDE,
  input  logic [PIX_W-1:0]     i_curr_grey,
  input  logic [PIX_W-1:0]     i_prev_grey,
  input  logic [PIX_W-1:0]     i_threshold,
  input  logic [CNT_W-1:0]     i_frame_thr,
  input  logic [1:0]           i_mode,
  output logic [3*CH_W-1:0]    o_vid_data,
  output logic                 o_vid_hsync,
  output logic                 o_vid_vsync,
  output logic                 o_vid_VDE,
  output logic [CNT_W-1:0]     o_motion_count,
  output logic                 o_motion_flag,
  output logic                 o_stats_valid
);

  localparam int unsigned DW  = 3 * CH_W;
  localparam int unsigned LAT = pipe_latency(RUN_LEN);

  typedef struct packed {
    logic [DW-1:0]    data;
    logic             hs;
    logic             vs;
    logic             vde;
    logic [PIX_W-1:0] diff;
  } pix_t;

  pix_t dl_q [LAT];
  pix_t dl_d [LAT];
  pix_t out;

  logic             vs_in_q;
  logic [PIX_W-1:0] thr_s_q, thr_s_d;
  logic [CNT_W-1:0] fthr_s_q, fthr_s_d;
  mode_e            mode_s_q, mode_s_d;

  logic             vs_out_q;
  logic             primed_q, primed_d;
  logic [CNT_W-1:0] count_q, count_d, count_inc;
  logic [CNT_W-1:0] fthr_frame_q, fthr_frame_d;
  logic [CNT_W-1:0] motion_count_q, motion_count_d;
  logic             motion_flag_q, motion_flag_d;
  logic             stats_valid_q, stats_valid_d;

  logic             flag_d;
  logic             marked;
  logic [CH_W-1:0]  diff_ch;
  logic             vs_rise_in, vs_rise_out;

  // dl_q[0] is the diff stage; dl_q[LAT-1] lines up with the run filter's centre pixel.
  always_comb begin
    dl_d[0].data = i_vid_data;
    dl_d[0].hs   = i_vid_hsync;
    dl_d[0].vs   = i_vid_vsync;
    dl_d[0].vde  = i_vid_VDE;
    dl_d[0].diff = (i_curr_grey >= i_prev_grey) ? (i_curr_grey - i_prev_grey)
                                                 : (i_prev_grey - i_curr_grey);
    for (int k = 1; k < LAT; k++) begin
      dl_d[k] = dl_q[k-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < LAT; k++) begin
        dl_q[k] <= '0;
      end
    end else begin
      dl_q <= dl_d;
    end
  end

  assign out    = dl_q[LAT-1];
  assign flag_d = dl_q[0].vde && (dl_q[0].diff > thr_s_q);

  motion_run_filter #(
    .RUN_LEN (RUN_LEN)
  ) u_run_filter (
    .clk      (clk),
    .rst      (rst),
    .flag_i   (flag_d),
    .marked_o (marked)
  );

  // Shadow configuration, reloaded once per frame on the input vsync rise.
  assign vs_rise_in = i_vid_vsync & ~vs_in_q;

  always_comb begin
    thr_s_d  = thr_s_q;
    fthr_s_d = fthr_s_q;
    mode_s_d = mode_s_q;
    if (vs_rise_in) begin
      thr_s_d  = i_threshold;
      fthr_s_d = i_frame_thr;
      mode_s_d = mode_e'(i_mode);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vs_in_q  <= 1'b0;
      thr_s_q  <= DEF_THRESHOLD;
      fthr_s_q <= '1;
      mode_s_q <= MODE_PASS;
    end else begin
      vs_in_q  <= i_vid_vsync;
      thr_s_q  <= thr_s_d;
      fthr_s_q <= fthr_s_d;
      mode_s_q <= mode_s_d;
    end
  end

  // Diff view: MSB-align the grey difference into each colour channel.
  if (CH_W == PIX_W) begin : g_diff_eq
    assign diff_ch = out.diff;
  end else if (CH_W > PIX_W) begin : g_diff_pad
    assign diff_ch = {out.diff, {(CH_W-PIX_W){1'b0}}};
  end else begin : g_diff_trunc
    assign diff_ch = out.diff[PIX_W-1 -: CH_W];
  end

  always_comb begin
    o_vid_data = '0;
    if (out.vde) begin
      case (mode_s_q)
        MODE_PASS:    o_vid_data = out.data;
        MODE_OVERLAY: o_vid_data = marked ? OVERLAY : out.data;
        MODE_MASK:    o_vid_data = marked ? '1 : '0;
        MODE_DIFF:    o_vid_data = {3{diff_ch}};
        default:      o_vid_data = out.data;
      endcase
    end
  end

  assign o_vid_hsync = out.hs;
  assign o_vid_vsync = out.vs;
  assign o_vid_VDE   = out.vde;

  // Statistics. fthr_frame_q holds the frame threshold that was in force while the
  // frame being counted was streaming out; fthr_s_q already belongs to the next frame.
  assign vs_rise_out = out.vs & ~vs_out_q;
  assign count_inc   = (out.vde && marked && (count_q != '1)) ? count_q + CNT_W'(1) : count_q;

  always_comb begin
    count_d        = count_inc;
    fthr_frame_d   = fthr_frame_q;
    primed_d       = primed_q;
    motion_count_d = motion_count_q;
    motion_flag_d  = motion_flag_q;
    stats_valid_d  = 1'b0;
    if (vs_rise_out) begin
      count_d      = '0;
      fthr_frame_d = fthr_s_q;
      primed_d     = 1'b1;
      if (primed_q) begin
        motion_count_d = count_inc;
        motion_flag_d  = count_inc > fthr_frame_q;
        stats_valid_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vs_out_q       <= 1'b0;
      primed_q       <= 1'b0;
      count_q        <= '0;
      fthr_frame_q   <= '1;
      motion_count_q <= '0;
      motion_flag_q  <= 1'b0;
      stats_valid_q  <= 1'b0;
    end else begin
      vs_out_q       <= out.vs;
      primed_q       <= primed_d;
      count_q        <= count_d;
      fthr_frame_q   <= fthr_frame_d;
      motion_count_q <= motion_count_d;
      motion_flag_q  <= motion_flag_d;
      stats_valid_q  <= stats_valid_d;
    end
  end

  assign o_motion_count = motion_count_q;
  assign o_motion_flag  = motion_flag_q;
  assign o_stats_valid  = stats_valid_q;

endmodule

// File: tb/tb_motion_threshold_filter.sv
// Directed bench for motion_threshold_filter (RUN_LEN=3, L=4) plus a CNT_W=4 copy
// sharing the same stimulus to exercise counter saturation.
module tb_motion_threshold_filter;

  localparam int L    = 4;
  localparam int LOGN = 16384;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [23:0] i_vid_data = '0;
  logic        i_vid_hsync = 1'b0, i_vid_vsync = 1'b0, i_vid_VDE = 1'b0;
  logic [7:0]  i_curr_grey = '0, i_prev_grey = '0, i_threshold = 8'd128;
  logic [21:0] i_frame_thr = '1;
  logic [3:0]  fthr_sat = '1;
  logic [1:0]  i_mode = 2'd0;

  logic [23:0] o_vid_data, s_vid_data;
  logic        o_vid_hsync, o_vid_vsync, o_vid_VDE, s_hs, s_vs, s_vde;
  logic [21:0] o_motion_count;
  logic [3:0]  s_count;
  logic        o_motion_flag, o_stats_valid, s_flag, s_valid;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [23:0] log_data  [LOGN];
  logic        log_vde   [LOGN];
  logic        log_hs    [LOGN];
  logic        log_valid [LOGN];
  logic        log_flag  [LOGN];
  logic [21:0] log_cnt   [LOGN];
  logic [3:0]  log_scnt  [LOGN];
  logic        log_sflag [LOGN];

  motion_threshold_filter dut (
    .clk(clk), .rst(rst), .i_vid_data(i_vid_data), .i_vid_hsync(i_vid_hsync),
    .i_vid_vsync(i_vid_vsync), .i_vid_VDE(i_vid_VDE), .i_curr_grey(i_curr_grey),
    .i_prev_grey(i_prev_grey), .i_threshold(i_threshold), .i_frame_thr(i_frame_thr),
    .i_mode(i_mode), .o_vid_data(o_vid_data), .o_vid_hsync(o_vid_hsync),
    .o_vid_vsync(o_vid_vsync), .o_vid_VDE(o_vid_VDE), .o_motion_count(o_motion_count),
    .o_motion_flag(o_motion_flag), .o_stats_valid(o_stats_valid)
  );

  motion_threshold_filter #(.CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst), .i_vid_data(i_vid_data), .i_vid_hsync(i_vid_hsync),
    .i_vid_vsync(i_vid_vsync), .i_vid_VDE(i_vid_VDE), .i_curr_grey(i_curr_grey),
    .i_prev_grey(i_prev_grey), .i_threshold(i_threshold), .i_frame_thr(fthr_sat),
    .i_mode(i_mode), .o_vid_data(s_vid_data), .o_vid_hsync(s_hs),
    .o_vid_vsync(s_vs), .o_vid_VDE(s_vde), .o_motion_count(s_count),
    .o_motion_flag(s_flag), .o_stats_valid(s_valid)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (cyc < LOGN) begin
      log_data[cyc]  <= o_vid_data;
      log_vde[cyc]   <= o_vid_VDE;
      log_hs[cyc]    <= o_vid_hsync;
      log_valid[cyc] <= o_stats_valid;
      log_flag[cyc]  <= o_motion_flag;
      log_cnt[cyc]   <= o_motion_count;
      log_scnt[cyc]  <= s_count;
      log_sflag[cyc] <= s_flag;
    end
  end

  // Input set now is sampled by the next posedge; its output is logged at index cyc+L.
  task automatic drive(input logic vde, input logic hs, input logic vs,
                       input logic [7:0] cu, input logic [7:0] pv, input logic [23:0] d);
    i_vid_VDE = vde; i_vid_hsync = hs; i_vid_vsync = vs;
    i_curr_grey = cu; i_prev_grey = pv; i_vid_data = d;
    @(posedge clk);
    #1;
  endtask

  task automatic pix(input logic [7:0] cu, input logic [7:0] pv, input logic [23:0] d);
    drive(1'b1, 1'b0, 1'b0, cu, pv, d);
  endtask

  // Blanking carries junk data and a large diff that must never show or be flagged.
  task automatic blank(input int n);
    repeat (n) drive(1'b0, 1'b1, 1'b0, 8'd200, 8'd50, 24'hC0FFEE);
  endtask

  task automatic vsync_pulse(output int rise);
    blank(L + 2);
    rise = cyc;
    repeat (3) drive(1'b0, 1'b0, 1'b1, 8'd200, 8'd50, 24'hC0FFEE);
    blank(L + 2);
  endtask

  task automatic frame_500();
    for (int ln = 0; ln < 5; ln++) begin
      repeat (100) pix(8'd200, 8'd50, 24'h101010);
      blank(3);
    end
  endtask

  task automatic test_reset();
    int t0;
    #1 rst = 1'b1;
    #2;
    n_tests++;
    if ({o_vid_data, o_vid_hsync, o_vid_vsync, o_vid_VDE} !== 27'd0) begin
      n_fail++; $display("FAIL reset_video: got %h expected 0",
                         {o_vid_data, o_vid_hsync, o_vid_vsync, o_vid_VDE});
    end
    n_tests++;
    if ({o_motion_count, o_motion_flag, o_stats_valid} !== 24'd0) begin
      n_fail++; $display("FAIL reset_stats: got %h expected 0",
                         {o_motion_count, o_motion_flag, o_stats_valid});
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    blank(2);
    t0 = cyc;
    repeat (3) pix(8'd200, 8'd50, 24'h123456);
    blank(L + 2);
    n_tests++;
    if ({log_vde[t0+L-1], log_data[t0+L-1]} !== 25'd0) begin
      n_fail++; $display("FAIL reset_latency_blank: got %h expected 0", log_data[t0+L-1]);
    end
    for (int i = 0; i < 3; i++) begin
      n_tests++;
      if (log_data[t0+L+i] !== 24'h123456) begin
        n_fail++; $display("FAIL reset_mode_pass[%0d]: got %h expected 123456", i,
                           log_data[t0+L+i]);
      end
    end
  endtask

  task automatic test_overlay();
    int r, t0, t1;
    i_mode = 2'd1; i_threshold = 8'd128;
    vsync_pulse(r);
    t0 = cyc;
    repeat (10) pix(8'd200, 8'd50, 24'h123456);
    blank(3);
    t1 = cyc;
    repeat (10) pix(8'd100, 8'd100, 24'hABCDEF);
    blank(L + 2);
    for (int i = 0; i < 10; i++) begin
      n_tests++;
      if (log_data[t0+L+i] !== 24'hFF0000) begin
        n_fail++; $display("FAIL overlay_red[%0d]: got %h expected ff0000", i, log_data[t0+L+i]);
      end
      n_tests++;
      if (log_data[t1+L+i] !== 24'hABCDEF) begin
        n_fail++; $display("FAIL overlay_still[%0d]: got %h expected abcdef", i,
                           log_data[t1+L+i]);
      end
    end
    n_tests++;
    if ({log_hs[t0+L-1], log_hs[t0+L]} !== 2'b10) begin
      n_fail++; $display("FAIL hsync_latency: got %b expected 10", {log_hs[t0+L-1], log_hs[t0+L]});
    end
    n_tests++;
    if (log_data[t0+L+10] !== 24'h0) begin
      n_fail++; $display("FAIL blank_zero: got %h expected 0", log_data[t0+L+10]);
    end
  endtask

  task automatic test_threshold_boundary();
    int r, t0;
    logic [23:0] exp_v;
    i_mode = 2'd2;
    vsync_pulse(r);
    t0 = cyc;
    repeat (3) pix(8'd228, 8'd100, 24'h111111);
    blank(2);
    repeat (3) pix(8'd229, 8'd100, 24'h111111);
    blank(2);
    repeat (3) pix(8'd50, 8'd200, 24'h111111);
    blank(L + 2);
    for (int i = 0; i < 13; i++) begin
      exp_v = ((i >= 5 && i <= 7) || i >= 10) ? 24'hFFFFFF : 24'h0;
      n_tests++;
      if (log_data[t0+L+i] !== exp_v) begin
        n_fail++; $display("FAIL thr_boundary[%0d]: got %h expected %h", i, log_data[t0+L+i], exp_v);
      end
    end
  endtask

  task automatic test_run_filter();
    int t0, t1;
    logic [9:0] pat, mk;
    logic [23:0] exp_v;
    pat = 10'b0110111000;
    mk  = 10'b0000111000;
    t0 = cyc;
    for (int i = 0; i < 10; i++) begin
      if (pat[9-i]) pix(8'd200, 8'd50, 24'h222222);
      else          pix(8'd100, 8'd100, 24'h222222);
    end
    blank(3);
    t1 = cyc;
    repeat (2) pix(8'd200, 8'd50, 24'h222222);
    blank(1);
    repeat (2) pix(8'd200, 8'd50, 24'h222222);
    blank(L + 2);
    for (int i = 0; i < 10; i++) begin
      exp_v = mk[9-i] ? 24'hFFFFFF : 24'h0;
      n_tests++;
      if (log_data[t0+L+i] !== exp_v) begin
        n_fail++; $display("FAIL run_pattern[%0d]: got %h expected %h", i, log_data[t0+L+i], exp_v);
      end
    end
    for (int i = 0; i < 5; i++) begin
      n_tests++;
      if (log_data[t1+L+i] !== 24'h0) begin
        n_fail++; $display("FAIL run_hblank_split[%0d]: got %h expected 0", i, log_data[t1+L+i]);
      end
    end
  endtask

  task automatic test_diff_view();
    int r, t0;
    i_mode = 2'd3;
    vsync_pulse(r);
    t0 = cyc;
    pix(8'd200, 8'd50, 24'h0);
    pix(8'd3, 8'd10, 24'h0);
    pix(8'd0, 8'd255, 24'h0);
    blank(L + 2);
    n_tests++;
    if (log_data[t0+L] !== 24'h969696) begin
      n_fail++; $display("FAIL diff_view_150: got %h expected 969696", log_data[t0+L]);
    end
    n_tests++;
    if (log_data[t0+L+1] !== 24'h070707) begin
      n_fail++; $display("FAIL diff_view_7: got %h expected 070707", log_data[t0+L+1]);
    end
    n_tests++;
    if (log_data[t0+L+2] !== 24'hFFFFFF) begin
      n_fail++; $display("FAIL diff_view_255: got %h expected ffffff", log_data[t0+L+2]);
    end
  endtask

  task automatic test_shadow_threshold();
    int r, t0, t1, t2;
    i_mode = 2'd2; i_threshold = 8'd128;
    vsync_pulse(r);
    t0 = cyc;
    repeat (5) pix(8'd120, 8'd100, 24'h333333);
    blank(3);
    i_threshold = 8'd10;
    t1 = cyc;
    repeat (5) pix(8'd120, 8'd100, 24'h333333);
    vsync_pulse(r);
    t2 = cyc;
    repeat (5) pix(8'd120, 8'd100, 24'h333333);
    blank(L + 2);
    i_threshold = 8'd128;
    for (int i = 0; i < 5; i++) begin
      n_tests++;
      if ({log_data[t0+L+i], log_data[t1+L+i]} !== 48'h0) begin
        n_fail++; $display("FAIL shadow_held[%0d]: got %h/%h expected 0/0", i,
                           log_data[t0+L+i], log_data[t1+L+i]);
      end
      n_tests++;
      if (log_data[t2+L+i] !== 24'hFFFFFF) begin
        n_fail++; $display("FAIL shadow_applied[%0d]: got %h expected ffffff", i, log_data[t2+L+i]);
      end
    end
  endtask

  task automatic test_stats();
    int v1, v2, v3;
    i_mode = 2'd1; i_frame_thr = 22'd499; fthr_sat = 4'd14;
    vsync_pulse(v1);
    frame_500();
    i_frame_thr = 22'd500; fthr_sat = 4'd15;
    vsync_pulse(v2);
    frame_500();
    vsync_pulse(v3);
    n_tests++;
    if ({log_valid[v2+L], log_valid[v2+L+1], log_valid[v2+L+2]} !== 3'b010) begin
      n_fail++; $display("FAIL stats_pulse_a: got %b expected 010",
                         {log_valid[v2+L], log_valid[v2+L+1], log_valid[v2+L+2]});
    end
    n_tests++;
    if ({log_cnt[v2+L+1], log_flag[v2+L+1]} !== {22'd500, 1'b1}) begin
      n_fail++; $display("FAIL stats_a: got count %0d flag %b expected 500 1",
                         log_cnt[v2+L+1], log_flag[v2+L+1]);
    end
    n_tests++;
    if ({log_scnt[v2+L+1], log_sflag[v2+L+1]} !== {4'd15, 1'b1}) begin
      n_fail++; $display("FAIL stats_sat_a: got count %0d flag %b expected 15 1",
                         log_scnt[v2+L+1], log_sflag[v2+L+1]);
    end
    n_tests++;
    if ({log_valid[v3+L], log_valid[v3+L+1], log_valid[v3+L+2]} !== 3'b010) begin
      n_fail++; $display("FAIL stats_pulse_b: got %b expected 010",
                         {log_valid[v3+L], log_valid[v3+L+1], log_valid[v3+L+2]});
    end
    n_tests++;
    if ({log_cnt[v3+L+1], log_flag[v3+L+1]} !== {22'd500, 1'b0}) begin
      n_fail++; $display("FAIL stats_b: got count %0d flag %b expected 500 0",
                         log_cnt[v3+L+1], log_flag[v3+L+1]);
    end
    n_tests++;
    if ({log_scnt[v3+L+1], log_sflag[v3+L+1]} !== {4'd15, 1'b0}) begin
      n_fail++; $display("FAIL stats_sat_b: got count %0d flag %b expected 15 0",
                         log_scnt[v3+L+1], log_sflag[v3+L+1]);
    end
  endtask

  task automatic test_reset_midframe();
    int t0, v4, v5;
    i_frame_thr = 22'd6;
    repeat (6) pix(8'd200, 8'd50, 24'h123456);
    #3;
    n_tests++;
    if (o_vid_data !== 24'hFF0000) begin
      n_fail++; $display("FAIL pre_reset_overlay: got %h expected ff0000", o_vid_data);
    end
    rst = 1'b1;
    #1;
    n_tests++;
    if ({o_vid_data, o_vid_VDE, o_motion_count, o_stats_valid} !== 48'd0) begin
      n_fail++; $display("FAIL async_reset: got data %h vde %b count %0d expected 0",
                         o_vid_data, o_vid_VDE, o_motion_count);
    end
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    t0 = cyc;
    repeat (7) pix(8'd200, 8'd50, 24'h5A5A5A);
    vsync_pulse(v4);
    repeat (7) pix(8'd200, 8'd50, 24'h5A5A5A);
    vsync_pulse(v5);
    for (int i = 0; i < 7; i++) begin
      n_tests++;
      if (log_data[t0+L+i] !== 24'h5A5A5A) begin
        n_fail++; $display("FAIL post_reset_pass[%0d]: got %h expected 5a5a5a", i,
                           log_data[t0+L+i]);
      end
    end
    for (int i = 1; i <= L + 3; i++) begin
      n_tests++;
      if (log_valid[v4+i] !== 1'b0) begin
        n_fail++; $display("FAIL first_stats_suppressed[%0d]: got %b expected 0", i,
                           log_valid[v4+i]);
      end
    end
    n_tests++;
    if ({log_valid[v5+L+1], log_cnt[v5+L+1], log_flag[v5+L+1]} !== {1'b1, 22'd7, 1'b1}) begin
      n_fail++; $display("FAIL stats_after_reset: got valid %b count %0d flag %b expected 1 7 1",
                         log_valid[v5+L+1], log_cnt[v5+L+1], log_flag[v5+L+1]);
    end
  endtask

  initial begin
    test_reset();
    test_overlay();
    test_threshold_boundary();
    test_run_filter();
    test_diff_view();
    test_shadow_threshold();
    test_stats();
    test_reset_midframe();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/motion_threshold_filter.md
# motion_threshold_filter

Parametrised frame-differencing motion detector for the vid_io pixel path, sitting after the grayscale and previous-frame stages. It compares the current and previous grey values against a runtime threshold and removes isolated noise pixels with a 1-D horizontal opening filter. It then re-colours the video according to a runtime mode and reports per-frame motion statistics. Configuration is shadowed at frame start, so a frame is never processed with mixed settings.

## Interface
- CH_W, 8: bits per colour channel; DATA_WIDTH = 3*CH_W
- PIX_W, 8: grey sample width
- RUN_LEN, 3: opening window width in pixels, 1..16; 1 disables filtering
- CNT_W, 22: motion pixel counter width
- DEF_THRESHOLD, 128: reset value of the shadow threshold
- OVERLAY, {CH_W ones, zeros, zeros}: overlay colour (red)

Ports:
- clk  in  1  pixel clock
- rst  in  1  reset; asynchronous, active-high
- i_vid_data  in  DATA_WIDTH  RGB pixel
- i_vid_hsync / i_vid_vsync / i_vid_VDE  in  1 each  syncs, active-high
- i_curr_grey, i_prev_grey  in  PIX_W  grey of current and previous frame at this pixel
- i_threshold  in  PIX_W  pixel motion threshold
- i_frame_thr  in  CNT_W  frame motion threshold
- i_mode  in  2  0 passthrough, 1 overlay, 2 binary mask, 3 diff view
- o_vid_data  out  DATA_WIDTH  processed pixel
- o_vid_hsync / o_vid_vsync / o_vid_VDE  out  1 each  delayed syncs
- o_motion_count  out  CNT_W  marked-pixel count of last completed frame
- o_motion_flag  out  1  o_motion_count > frame threshold of that frame
- o_stats_valid  out  1  one-cycle pulse when statistics update

## Operation
- Shadow registers: thr_s, fthr_s and mode_s load i_threshold, i_frame_thr and i_mode on the cycle after an i_vid_vsync rising edge. All stages use only the shadow values.
- Stage 1: diff = |i_curr_grey − i_prev_grey|, unsigned, PIX_W bits, no overflow. Data, syncs and VDE are registered alongside.
- Stage 2: flag = VDE & (diff > thr_s). diff == thr_s gives no flag.
- Run filter (1-D opening): a pixel is marked iff it lies inside at least one window of RUN_LEN consecutive cycles with flag = 1. Blanking cycles carry flag 0, so a run never spans a line or frame boundary. With RUN_LEN = 1, marked = flag.
- Output mux, applied only when VDE is high:
  - mode 0: data unchanged.
  - mode 1: OVERLAY if marked, else data.
  - mode 2: all ones if marked, else all zeros.
  - mode 3: each channel = diff MSB-aligned to CH_W, zero-padded or truncated.
- When VDE is low, o_vid_data = 0.
- Statistics:
  - count increments on every output cycle with VDE & marked, and saturates at 2^CNT_W−1.
  - On the rising edge of the delayed (output-side) vsync, count is latched to o_motion_count and o_motion_flag = (count > fthr_s in force for that frame). o_stats_valid pulses and count clears to 0.
  - If a marked pixel coincides with the latch cycle, the latched value includes it and count restarts at 0.

## Timing
- Pixel latency L = RUN_LEN + 1 cycles, identical for data, hsync, vsync and VDE. Throughput is 1 pixel/clock with no stalls.
- Reset (asynchronous assert, synchronous release to clk):
  - all outputs, pipeline registers, flag shift register and count go to 0;
  - thr_s = DEF_THRESHOLD, fthr_s = all ones, mode_s = 0.
- Reset asserted mid-frame: outputs are 0 immediately. The frame in progress produces no o_stats_valid. The first statistics appear at the second output vsync rise after release; the first rise is suppressed via a primed bit.
- Source contract: VDE stays low for at least L cycles on each side of a vsync edge. Shadow updates are therefore never visible mid-frame.
- o_stats_valid asserts L+1 cycles after the i_vid_vsync rise and is high for exactly 1 cycle.

## Structure
- Shared package motion_pkg:
  - mode encodings MODE_PASS/OVERLAY/MASK/DIFF;
  - default OVERLAY colour;
  - function deriving L from RUN_LEN.
- Sub-module motion_run_filter: a flag shift register of 2·RUN_LEN−1 bits, an AND per window and an OR reduction, with fixed RUN_LEN−1 latency. The top level holds the diff/compare stages, the matching delay line, the output mux, the shadow registers and the statistics.

## Test plan
- Defaults, mode 1, curr=200, prev=50 on a 10-pixel VDE run → pixels red at L=4; curr=prev=100 → data unchanged.
- diff exactly 128 with threshold 128 → no mark; 129 → marked; curr<prev (50, 200) → marked, confirming absolute difference.
- RUN_LEN=3, flag pattern 0110111000 → only the 3-run marked (positions 4–6); isolated pairs removed. A run split by hblank is not joined.
- i_threshold changed mid-frame from 128 to 10 → no change until the next vsync rise, then applied from the first pixel of the next frame.
- Frame with 500 marked pixels, i_frame_thr=499 → o_motion_count=500, flag=1, single-cycle valid at L+1 after the vsync rise; with i_frame_thr=500, flag=0. Saturation is forced via CNT_W=4.
- rst pulsed mid-frame → all outputs 0 asynchronously, shadow threshold back to 128. The first stats pulse is suppressed and appears only after one complete frame.
